// File: rtl/fp_mul_arb.sv
// Round-robin scheduler sharing one pipelined fp_mul among NREQ requesters.
// Tags ride a shadow pipeline so each product is steered back to its originator.
module fp_mul_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic                           clk,
  input  logic                           areset_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [32*NREQ-1:0]             req_a,
  input  logic [32*NREQ-1:0]             req_b,
  output logic [NREQ-1:0]                rsp_valid,
  input  logic [NREQ-1:0]                rsp_ready,
  output logic [31:0]                    rsp_q,
  output logic [31:0]                    mul_a,
  output logic [31:0]                    mul_b,
  output logic                           mul_en,
  output logic                           mul_areset,
  input  logic [31:0]                    mul_q,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [TW-1:0]               last_q;
  logic [LATENCY-1:0]          vld_q;
  logic [LATENCY-1:0][TW-1:0]  tag_q;
  logic [CW-1:0]               inflight_q;

  logic [TW-1:0] start, grant, head_tag;
  logic          head_vld, stall, issue, complete, found;
  int unsigned   idx;

  // Search starts one past the last winner and wraps; with no requester the
  // start index still selects the (don't-care) operands.
  always_comb begin
    start = (last_q == TW'(NREQ - 1)) ? '0 : last_q + TW'(1);
    grant = start;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(start) + k) % NREQ;
      if (!found && req_valid[idx[TW-1:0]]) begin
        found = 1'b1;
        grant = idx[TW-1:0];
      end
    end
  end

  always_comb begin
    head_vld   = vld_q[LATENCY-1];
    head_tag   = tag_q[LATENCY-1];
    stall      = head_vld & ~rsp_ready[head_tag];
    issue      = areset_n & (|req_valid) & ~stall;
    complete   = head_vld & ~stall;
    mul_en     = ~stall;
    mul_areset = ~areset_n;
    mul_a      = req_a[32*grant +: 32];
    mul_b      = req_b[32*grant +: 32];
    rsp_q      = mul_q;
    inflight   = inflight_q;
    req_ready  = '0;
    if (issue) req_ready[grant] = 1'b1;
    rsp_valid  = '0;
    if (head_vld) rsp_valid[head_tag] = 1'b1;
  end

  // Everything freezes together with fp_mul while the head is back-pressured.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_q      <= '0;
      tag_q      <= '0;
      last_q     <= TW'(NREQ - 1);
      inflight_q <= '0;
    end else if (!stall) begin
      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      vld_q[0] <= issue;
      tag_q[0] <= grant;
      if (issue) last_q <= grant;
      if (issue && !complete) begin
        inflight_q <= inflight_q + CW'(1);
      end else if (!issue && complete) begin
        inflight_q <= inflight_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_arb.sv
// Bench for fp_mul_arb: behavioural fp_mul stand-in plus a timestamped op-queue model.
module tb_fp_mul_arb;

  localparam int NREQ    = 4;
  localparam int LATENCY = 3;
  localparam int CW      = $clog2(LATENCY + 1);

  logic                clk = 1'b0;
  logic                areset_n;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [31:0]         rsp_q, mul_a, mul_b, mul_q;
  logic                mul_en, mul_areset;
  logic [CW-1:0]       inflight;

  fp_mul_arb #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_q      (rsp_q),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_areset (mul_areset),
    .mul_q      (mul_q),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  // Single-precision multiply for normal operands, via exact double product and RNE.
  function automatic logic [63:0] s2d(input logic [31:0] x);
    return {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    logic [30:0] mag;
    p   = $bitstoreal(s2d(a)) * $bitstoreal(s2d(b));
    d   = $realtobits(p);
    mag = {8'(int'(d[62:52]) - 896), d[51:29]};
    if (d[28:0] > 29'h1000_0000 || (d[28:0] == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  // fp_mul stand-in: LATENCY enabled edges from operand sample to q.
  logic [31:0] mpipe [LATENCY];
  always @(posedge clk or posedge mul_areset) begin
    if (mul_areset) begin
      for (int i = 0; i < LATENCY; i++) mpipe[i] <= '0;
    end else if (mul_en) begin
      mpipe[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_q = mpipe[LATENCY-1];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: ops in issue order, stamped with the enabled-edge count at issue.
  typedef struct { int tag; logic [31:0] prod; int t; } op_t;
  op_t mq[$];
  int  model_last = NREQ - 1;
  int  en_cnt     = 0;
  int  cyc        = 0;

  int          obs_g[$], obs_gcyc[$], obs_rtag[$], obs_rcyc[$];
  logic [31:0] obs_rq[$];
  logic        last_mul_en;
  logic [31:0] last_rsp_q;
  int          last_inflight;

  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return (last + 1) % NREQ;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
  endfunction

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic clear_logs();
    obs_g.delete(); obs_gcyc.delete(); obs_rtag.delete(); obs_rcyc.delete(); obs_rq.delete();
  endtask

  // Called at a negedge with inputs driven; checks, advances model, returns at next negedge.
  task automatic step();
    logic            hv, stl, any;
    int              htag, g;
    logic [NREQ-1:0] exp_ready, exp_rv;
    #1;
    any  = |req_valid;
    hv   = (mq.size() > 0) && (en_cnt - mq[0].t == LATENCY - 1);
    htag = hv ? mq[0].tag : 0;
    stl  = hv && !rsp_ready[htag];
    g    = pick(model_last, req_valid);
    exp_ready = (any && !stl) ? NREQ'(1 << g) : '0;
    exp_rv    = hv ? NREQ'(1 << htag) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("mul_en", 32'(mul_en), 32'(!stl));
    check("inflight", 32'(inflight), 32'(mq.size()));
    if (hv) check("rsp_q", rsp_q, mq[0].prod);
    last_mul_en   = mul_en;
    last_rsp_q    = rsp_q;
    last_inflight = int'(inflight);
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin obs_g.push_back(i); obs_gcyc.push_back(cyc); end
      if (rsp_valid[i] && rsp_ready[i]) begin
        obs_rtag.push_back(i); obs_rcyc.push_back(cyc); obs_rq.push_back(rsp_q);
      end
    end
    if (!stl) begin
      en_cnt++;
      if (hv) void'(mq.pop_front());
      if (any) begin
        mq.push_back('{tag: g, prod: fmul(req_a[32*g +: 32], req_b[32*g +: 32]), t: en_cnt});
        model_last = g;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mul_en", 32'(mul_en), 1);
    check("rst_mul_areset", 32'(mul_areset), 1);
    check("rst_inflight", 32'(inflight), 0);
    mq.delete();
    model_last = NREQ - 1;
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 4 * LATENCY + 4; k++) step();
  endtask

  int exp_wrap [4] = '{0, 3, 0, 3};
  int stall_cnt;

  initial begin
    areset_n  = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    do_reset();

    // Single op
    clear_logs();
    req_valid = '0;
    set_ops(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();
    check("single_issues", obs_g.size(), 1);
    check("single_rsps", obs_rtag.size(), 1);
    if (obs_rq.size() == 1 && obs_gcyc.size() == 1) begin
      check("single_q", obs_rq[0], 32'h40C00000);
      check("single_lat", obs_rcyc[0] - obs_gcyc[0], LATENCY);
    end

    // Round robin
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'h3FC00000, 32'h3FC00000);
    req_valid = '1;
    for (int k = 0; k < 12; k++) step();
    drain();
    check("rr_issues", obs_g.size(), 12);
    check("rr_rsps", obs_rtag.size(), 12);
    for (int i = 0; i < 12 && i < obs_g.size() && i < obs_rtag.size(); i++) begin
      check("rr_grant", obs_g[i], i % NREQ);
      check("rr_rsp_tag", obs_rtag[i], i % NREQ);
      check("rr_rsp_q", obs_rq[i], 32'h40100000);
    end

    // Back-pressure on requester 1
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_ops(i, rand_fp(), rand_fp());
    set_ops(1, 32'h3DCCCCCD, 32'h3E4CCCCD);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0101;
    stall_cnt = 0;
    for (int k = 0; k < 40 && stall_cnt < 5; k++) begin
      step();
      if (!last_mul_en) begin
        stall_cnt++;
        check("bp_hold_q", last_rsp_q, 32'h3CA3D70B);
      end
    end
    check("bp_stalls", stall_cnt, 5);
    drain();
    check("bp_all_rsps", obs_rtag.size(), obs_g.size());
    if (obs_rtag.size() > 0) check("bp_first_tag", obs_rtag[0], 1);

    // Wrap and fairness
    do_reset();
    clear_logs();
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) step();
    drain();
    check("wrap_issues", obs_g.size(), 4);
    for (int i = 0; i < 4 && i < obs_g.size(); i++) check("wrap_grant", obs_g[i], exp_wrap[i]);

    // Reset mid-flight
    do_reset();
    rsp_ready = '1;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    req_valid = '0;
    do_reset();
    clear_logs();
    for (int k = 0; k < 6; k++) step();
    check("rst_no_rsp", obs_rtag.size(), 0);
    set_ops(2, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    step();
    drain();
    check("rst_new_rsps", obs_rtag.size(), 1);
    if (obs_rtag.size() == 1) begin
      check("rst_new_tag", obs_rtag[0], 2);
      check("rst_new_q", obs_rq[0], 32'h40C00000);
    end

    // Saturation
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_ops(i, rand_fp(), rand_fp());
    req_valid = '1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k >= LATENCY) check("sat_inflight", last_inflight, LATENCY);
    end
    check("sat_issues", obs_g.size(), 20);
    drain();

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(199, 0) == 0) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, rand_fp(), rand_fp());
        req_valid[i] = ($urandom_range(2, 0) != 0);
        rsp_ready[i] = ($urandom_range(3, 0) != 0);
      end
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
